fadd_seq: RTL and testbench

Multi-cycle IEEE-754 single-precision add/subtract sequencer built around one shared instance of the team's integer `adder` block, parameterized to 25 bits. The block steps that adder through several roles: exponent compare, exponent re-difference, mantissa add/subtract, negation, and exponent increment/decrement during normalization. It sits between the `f_adder` top level and the integer adder, and trades latency for area. Rounding is truncation (round toward zero), and denormals are flushed to zero.

---
 rtl/fadd_seq.sv | 245 ++++++++++++++++++++++++
 tb/tb_fadd_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fadd_seq.sv
// fadd_seq: multi-cycle IEEE-754 single-precision add/subtract (truncating,
// denormals flushed to zero) that routes all arithmetic through one shared
// integer adder, one operation per cycle.
// Ports:
//   clk, rst_n      clock (rising edge), synchronous active-low reset
//   start           request, sampled only while idle
//   sub             1: a-b, 0: a+b (applied to b's sign at capture)
//   a, b            operands, captured on acceptance
//   busy            high from the cycle after acceptance through the done cycle
//   done            one-cycle pulse, result valid
//   result          registered result, held until the next done

// Shared integer adder: op=1 adds, op=0 subtracts; on subtract carry flags in1>in0.
module adder #(
   parameter int unsigned WIDTH = 25
) (
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             op,
   output logic [WIDTH-1:0] out,
   output logic             carry
);
   logic [WIDTH:0] r;

   always_comb begin
      if (op) r = {1'b0, in0} + {1'b0, in1};
      else    r = {1'b0, in0} - {1'b0, in1};
   end

   assign out   = r[WIDTH-1:0];
   assign carry = r[WIDTH];
endmodule

module fadd_seq #(
   parameter int unsigned BITS_LENGTH = 32,
   parameter int unsigned ADD_W       = 25
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   sub,
   input  logic [BITS_LENGTH-1:0] a,
   input  logic [BITS_LENGTH-1:0] b,
   output logic                   busy,
   output logic                   done,
   output logic [BITS_LENGTH-1:0] result
);
   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 24;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_EXP   = 3'd1;
   localparam logic [2:0] S_SWAP  = 3'd2;
   localparam logic [2:0] S_ALIGN = 3'd3;
   localparam logic [2:0] S_MANT  = 3'd4;
   localparam logic [2:0] S_NEG   = 3'd5;
   localparam logic [2:0] S_NORM  = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   logic [2:0]             state, state_nxt;
   logic                   sa, sa_nxt, sb, sb_nxt, sr, sr_nxt;
   logic [EXP_W-1:0]       ea, ea_nxt, eb, eb_nxt, ew, ew_nxt, diff, diff_nxt;
   logic [MAN_W-1:0]       ma, ma_nxt, mb, mb_nxt;
   logic [ADD_W-1:0]       sum, sum_nxt;
   logic                   busy_nxt, done_nxt;
   logic [BITS_LENGTH-1:0] result_nxt;

   logic [ADD_W-1:0]       add_in0, add_in1, add_out;
   logic                   add_op, add_carry;

   adder #(.WIDTH(ADD_W)) u_adder (
      .in0   (add_in0),
      .in1   (add_in1),
      .op    (add_op),
      .out   (add_out),
      .carry (add_carry)
   );

   // Adder operand select: what the shared adder computes in each state.
   always_comb begin
      add_in0 = '0;
      add_in1 = '0;
      add_op  = 1'b1;
      case (state)
         S_EXP: begin
            add_in0 = ADD_W'(ea);
            add_in1 = ADD_W'(eb);
            add_op  = 1'b0;
         end
         // Operands are exchanged this cycle, so the difference is eb-ea of the old values.
         S_SWAP: begin
            add_in0 = ADD_W'(eb);
            add_in1 = ADD_W'(ea);
            add_op  = 1'b0;
         end
         S_MANT: begin
            add_in0 = ADD_W'(ma);
            add_in1 = ADD_W'(mb);
            add_op  = (sa == sb);
         end
         S_NEG: begin
            add_in0 = '0;
            add_in1 = sum;
            add_op  = 1'b0;
         end
         S_NORM: begin
            add_in0 = ADD_W'(ew);
            add_in1 = ADD_W'(1);
            add_op  = sum[ADD_W-1];
         end
         default: ;
      endcase
   end

   // Next-state and datapath update.
   always_comb begin
      state_nxt  = state;
      sa_nxt     = sa;
      sb_nxt     = sb;
      sr_nxt     = sr;
      ea_nxt     = ea;
      eb_nxt     = eb;
      ew_nxt     = ew;
      diff_nxt   = diff;
      ma_nxt     = ma;
      mb_nxt     = mb;
      sum_nxt    = sum;
      busy_nxt   = busy;
      result_nxt = result;
      case (state)
         S_IDLE: begin
            if (start) begin
               sa_nxt    = a[31];
               sb_nxt    = b[31] ^ sub;
               ea_nxt    = a[30:23];
               eb_nxt    = b[30:23];
               ma_nxt    = (a[30:23] != 8'd0) ? {1'b1, a[22:0]} : '0;
               mb_nxt    = (b[30:23] != 8'd0) ? {1'b1, b[22:0]} : '0;
               busy_nxt  = 1'b1;
               state_nxt = S_EXP;
            end
         end
         S_EXP: begin
            if (ea == 8'hFF || eb == 8'hFF) begin
               result_nxt = 32'h7FC0_0000;
               state_nxt  = S_DONE;
            end else if (add_carry) begin
               state_nxt = S_SWAP;
            end else begin
               diff_nxt  = add_out[EXP_W-1:0];
               state_nxt = S_ALIGN;
            end
         end
         S_SWAP: begin
            sa_nxt    = sb;
            sb_nxt    = sa;
            ea_nxt    = eb;
            eb_nxt    = ea;
            ma_nxt    = mb;
            mb_nxt    = ma;
            diff_nxt  = add_out[EXP_W-1:0];
            state_nxt = S_ALIGN;
         end
         S_ALIGN: begin
            mb_nxt    = (diff >= 8'd25) ? '0 : (mb >> diff);
            ew_nxt    = ea;
            sr_nxt    = sa;
            state_nxt = S_MANT;
         end
         S_MANT: begin
            sum_nxt   = add_out;
            // Borrow only arises when ma<mb on a true subtract: magnitude must be negated.
            state_nxt = ((sa != sb) && add_carry) ? S_NEG : S_NORM;
         end
         S_NEG: begin
            sum_nxt   = add_out;
            sr_nxt    = sb;
            state_nxt = S_NORM;
         end
         S_NORM: begin
            if (sum == '0) begin
               result_nxt = 32'h0000_0000;
               state_nxt  = S_DONE;
            end else if (sum[ADD_W-1]) begin
               sum_nxt = sum >> 1;
               ew_nxt  = add_out[EXP_W-1:0];
               if (add_out[EXP_W-1:0] == 8'hFF) begin
                  result_nxt = {sr, 8'hFF, 23'd0};
                  state_nxt  = S_DONE;
               end
            end else if (sum[ADD_W-2]) begin
               result_nxt = {sr, ew, sum[22:0]};
               state_nxt  = S_DONE;
            end else if (ew <= 8'd1) begin
               result_nxt = {sr, 31'd0};
               state_nxt  = S_DONE;
            end else begin
               sum_nxt = sum << 1;
               ew_nxt  = add_out[EXP_W-1:0];
            end
         end
         S_DONE: begin
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
      done_nxt = (state_nxt == S_DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         sa     <= 1'b0;
         sb     <= 1'b0;
         sr     <= 1'b0;
         ea     <= '0;
         eb     <= '0;
         ew     <= '0;
         diff   <= '0;
         ma     <= '0;
         mb     <= '0;
         sum    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         sa     <= sa_nxt;
         sb     <= sb_nxt;
         sr     <= sr_nxt;
         ea     <= ea_nxt;
         eb     <= eb_nxt;
         ew     <= ew_nxt;
         diff   <= diff_nxt;
         ma     <= ma_nxt;
         mb     <= mb_nxt;
         sum    <= sum_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         result <= result_nxt;
      end
   end
endmodule

// File: tb/tb_fadd_seq.sv
// Bench for fadd_seq: closed-form reference model plus per-cycle compare.
module tb_fadd_seq;
   logic        clk = 1'b0;
   logic        rst_n, start, sub;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   always #5 clk = ~clk;

   fadd_seq dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .sub    (sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   bit chk_on = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: returns {latency, result}. Aligns and sums the signed
   // mantissas directly, then normalizes in closed form from the MSB position.
   function automatic logic [63:0] ref_model(input logic [31:0] x, input logic [31:0] y, input logic s);
      int ex, ey, ebig, esm, d, p, k, e, steps, extra;
      longint mx, my, mbig, msm, tot, mag;
      logic sx, sy, sbig, ssm, sr;
      logic [31:0] res;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      sx = x[31];
      sy = y[31] ^ s;
      if (ex == 255 || ey == 255) return {32'd2, 32'h7FC0_0000};
      mx = (ex != 0) ? longint'({1'b1, x[22:0]}) : 0;
      my = (ey != 0) ? longint'({1'b1, y[22:0]}) : 0;
      extra = 0;
      if (ex < ey) begin
         ebig = ey; esm = ex; mbig = my; msm = mx; sbig = sy; ssm = sx; extra = 1;
      end else begin
         ebig = ex; esm = ey; mbig = mx; msm = my; sbig = sx; ssm = sy;
      end
      d = ebig - esm;
      msm = (d >= 25) ? 0 : (msm >> d);
      tot = (sbig ? -mbig : mbig) + (ssm ? -msm : msm);
      if (sbig != ssm && mbig < msm) extra++;
      sr  = (tot < 0);
      mag = sr ? -tot : tot;
      e = ebig;
      if (mag == 0) begin
         res = 32'h0; steps = 1;
      end else begin
         p = 0;
         for (int i = 0; i < 25; i++) if (mag[i]) p = i;
         if (p == 24) begin
            if (e + 1 == 255) begin
               res = {sr, 8'hFF, 23'd0}; steps = 1;
            end else begin
               res = {sr, 8'(e + 1), 23'(mag >> 1)}; steps = 2;
            end
         end else begin
            k = 23 - p;
            if (e - k >= 1) begin
               res = {sr, 8'(e - k), 23'(mag << k)}; steps = k + 1;
            end else begin
               res = {sr, 31'd0}; steps = e;
            end
         end
      end
      return {32'(4 + extra + steps), res};
   endfunction

   // Cycle-level expectation of busy/done/result driven by the reference.
   logic        m_busy, m_done;
   logic [31:0] m_res, pend, lat_q;
   int          k_cyc;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_res  <= 32'h0;
         k_cyc  <= 0;
      end else if (!m_busy) begin
         if (start) begin
            {lat_q, pend} <= ref_model(a, b, sub);
            m_busy <= 1'b1;
            k_cyc  <= 1;
         end
      end else if (m_done) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
      end else begin
         k_cyc <= k_cyc + 1;
         if (32'(k_cyc + 1) == lat_q) begin
            m_done <= 1'b1;
            m_res  <= pend;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         check("busy", 32'(busy), 32'(m_busy));
         check("done", 32'(done), 32'(m_done));
         check("result", result, m_res);
         if (done === 1'b1) done_cnt <= done_cnt + 1;
      end
   end

   task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                         input logic [31:0] er, input int el, input int hold, input string name);
      int n;
      bit got;
      @(negedge clk);
      a = x; b = y; sub = s; start = 1'b1;
      @(posedge clk);
      n = 0; got = 0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         n++;
         if (n > hold) start = 1'b0;
         if (done === 1'b1) got = 1;
      end
      start = 1'b0;
      check({name, "_lat"}, 32'(n), 32'(el));
      check({name, "_res"}, result, er);
      @(negedge clk);
   endtask

   logic [31:0] ta[9], tbv[9], tr[9];
   logic        ts[9];
   int          tl[9];

   function automatic logic [63:0] gen_pair();
      logic [31:0] x, y;
      int mode, ey;
      x = $urandom;
      y = $urandom;
      mode = $urandom_range(0, 9);
      if (mode <= 4) begin
         ey = int'(x[30:23]) + int'($urandom_range(0, 8)) - 4;
         if (ey < 0) ey = 0;
         if (ey > 255) ey = 255;
         y[30:23] = 8'(ey);
      end else if (mode == 5) begin
         y = x ^ 32'h0000_0001;
      end else if (mode == 6) begin
         y = x ^ 32'h8000_0000;
      end else if (mode == 8) begin
         x[30:23] = 8'($urandom_range(252, 255));
         y[30:23] = 8'($urandom_range(250, 254));
      end else if (mode == 9) begin
         x[30:23] = 8'($urandom_range(0, 3));
         y[30:23] = 8'($urandom_range(0, 3));
      end
      return {x, y};
   endfunction

   initial begin
      logic [63:0] rm;
      int d0;
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      ta  = '{32'h3F80_0000, 32'h3FC0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF,
              32'h7F80_0000, 32'h0000_0001, 32'h3F80_0000, 32'h0080_0000};
      tbv = '{32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 32'h7F7F_FFFF,
              32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0001, 32'h0080_0001};
      ts  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      tr  = '{32'h4000_0000, 32'h3F00_0000, 32'hBF80_0000, 32'h0000_0000, 32'h7F80_0000,
              32'h7FC0_0000, 32'h3F80_0000, 32'hB400_0000, 32'h8000_0000};
      tl  = '{6, 6, 7, 5, 5, 2, 6, 29, 6};

      repeat (2) @(negedge clk);
      chk_on = 1;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_result", result, 32'h0);
      rst_n = 1'b1;

      // Pin the reference model to hand-computed values.
      for (int i = 0; i < 9; i++) begin
         rm = ref_model(ta[i], tbv[i], ts[i]);
         check("model_res", rm[31:0], tr[i]);
         check("model_lat", rm[63:32], 32'(tl[i]));
      end

      for (int i = 0; i < 9; i++) run_op(ta[i], tbv[i], ts[i], tr[i], tl[i], 0, "dir");

      // start held while busy must not produce a second operation.
      d0 = done_cnt;
      run_op(32'h3FC0_0000, 32'h3F80_0000, 1'b1, 32'h3F00_0000, 6, 3, "hold");
      repeat (8) @(negedge clk);
      check("hold_dones", 32'(done_cnt - d0), 32'd1);

      // Reset during NORM aborts the operation.
      @(negedge clk);
      a = 32'h3F80_0000; b = 32'h3F80_0000; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", 32'(busy), 32'h0);
      check("abort_done", 32'(done), 32'h0);
      check("abort_result", result, 32'h0);
      d0 = done_cnt;
      repeat (10) @(negedge clk);
      check("abort_nodone", 32'(done_cnt - d0), 32'd0);

      // Randomized traffic, including occasional resets.
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         {a, b} = gen_pair();
         sub   = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 3) == 0);
         rst_n = ($urandom_range(0, 599) != 0);
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
